ram_line_responder: RTL and testbench

Synthesizable responder for the cache-to-RAM line interface. It receives line-read and line-write requests from the cache's RAM port, stores 64-bit lines in an internal array, and returns read lines as a burst of 16-bit beats after a fixed latency. It sits on the RAM side of the cache's `ram_*` port and serves as the synthesizable counterpart to the simulation RAM stub.

---
 rtl/ram_line_responder.sv | 163 ++++++++++++++++
 tb/tb_ram_line_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ram_line_responder.sv
// Line-granular RAM responder for the cache ram_* port: 4-beat write collection, fixed-latency 4-beat read bursts.
// Optional define RAM_RESP_PATTERN_EN: unwritten lines read back an address-derived pattern instead of zero.
module ram_line_responder #(
    parameter int ADDR_SIZE  = 13,
    parameter int WORD_SIZE  = 16,
    parameter int LINE_WIDTH = 64,
    parameter int LATENCY    = 3
) (
    input  logic                 ram_clk,
    input  logic                 ram_rst,
    input  logic [ADDR_SIZE-1:0] ram_addr,
    input  logic                 ram_avalid,
    input  logic                 ram_rnw,
    input  logic [WORD_SIZE-1:0] ram_wdata,
    output logic [WORD_SIZE-1:0] ram_rdata,
    output logic                 ram_ack,
    output logic                 ram_busy
);

    localparam int BEATS = LINE_WIDTH / WORD_SIZE;
    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int BW    = $clog2(BEATS) + 1;

    typedef enum logic [2:0] {IDLE, WCOLLECT, WAIT, RBURST, WACK} state_t;

    state_t                 state;
    logic [ADDR_SIZE-1:0]   addr_q;
    logic                   rnw_q;
    logic [CW-1:0]          cnt;
    logic [BW-1:0]          beat;
    logic [LINE_WIDTH-1:0]  line_q;
    logic [LINE_WIDTH-1:0]  fetch_line;
    logic [LINE_WIDTH-1:0]  commit_line;
    logic                   commit;

    logic [LINE_WIDTH-1:0]  mem [DEPTH] = '{default: '0};

`ifdef RAM_RESP_PATTERN_EN
    logic [DEPTH-1:0]       written;

    function automatic logic [LINE_WIDTH-1:0] pattern_line(input logic [ADDR_SIZE-1:0] a);
        logic [LINE_WIDTH-1:0] l;
        l = '0;
        for (int unsigned k = 0; k < BEATS; k++) begin
            l[k*WORD_SIZE +: WORD_SIZE] = WORD_SIZE'({4'(k + 1), a[11:0]});
        end
        return l;
    endfunction
`endif

    // Last write beat arrives with ram_wdata; lower beats are already in line_q.
    assign commit      = (state == WCOLLECT) && (beat == BW'(BEATS - 1)) && !ram_rst;
    assign commit_line = {ram_wdata, line_q[LINE_WIDTH-WORD_SIZE-1:0]};

    always_comb begin
        fetch_line = mem[addr_q];
`ifdef RAM_RESP_PATTERN_EN
        if (!written[addr_q]) begin
            fetch_line = pattern_line(addr_q);
        end
`endif
    end

    // Storage has no reset so committed lines survive ram_rst.
    always_ff @(posedge ram_clk) begin
        if (commit) begin
            mem[addr_q] <= commit_line;
        end
    end

`ifdef RAM_RESP_PATTERN_EN
    always_ff @(posedge ram_clk) begin
        if (ram_rst) begin
            written <= '0;
        end else if (commit) begin
            written[addr_q] <= 1'b1;
        end
    end
`endif

    always_ff @(posedge ram_clk) begin
        if (ram_rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            rnw_q     <= 1'b0;
            cnt       <= '0;
            beat      <= '0;
            line_q    <= '0;
            ram_rdata <= '0;
            ram_ack   <= 1'b0;
            ram_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ram_ack   <= 1'b0;
                    ram_rdata <= '0;
                    if (ram_avalid) begin
                        addr_q   <= ram_addr;
                        rnw_q    <= ram_rnw;
                        ram_busy <= 1'b1;
                        cnt      <= CW'(LATENCY - 1);
                        if (ram_rnw) begin
                            state <= WAIT;
                        end else begin
                            line_q[WORD_SIZE-1:0] <= ram_wdata;
                            beat                  <= BW'(1);
                            state                 <= WCOLLECT;
                        end
                    end
                end
                WCOLLECT: begin
                    line_q[int'(beat)*WORD_SIZE +: WORD_SIZE] <= ram_wdata;
                    beat <= beat + 1'b1;
                    if (beat == BW'(BEATS - 1)) begin
                        cnt   <= CW'(LATENCY - 1);
                        state <= WAIT;
                    end
                end
                // The edge where cnt is already zero is the one that raises ram_ack,
                // so a latency of 1 needs no separate bypass path.
                WAIT: begin
                    if (cnt == '0) begin
                        ram_ack <= 1'b1;
                        if (rnw_q) begin
                            line_q    <= fetch_line;
                            ram_rdata <= fetch_line[WORD_SIZE-1:0];
                            beat      <= BW'(1);
                            state     <= RBURST;
                        end else begin
                            state <= WACK;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RBURST: begin
                    if (beat == BW'(BEATS)) begin
                        ram_ack   <= 1'b0;
                        ram_rdata <= '0;
                        ram_busy  <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        ram_rdata <= line_q[int'(beat)*WORD_SIZE +: WORD_SIZE];
                        beat      <= beat + 1'b1;
                    end
                end
                WACK: begin
                    ram_ack  <= 1'b0;
                    ram_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    ram_ack   <= 1'b0;
                    ram_rdata <= '0;
                    ram_busy  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_line_responder.sv
// Randomized self-checking bench for ram_line_responder: one instance at LATENCY=3, one at LATENCY=1.
module tb_ram_line_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    [2];
    logic        avalid [2];
    logic        rnw    [2];
    logic [12:0] addr   [2];
    logic [15:0] wdata  [2];
    logic [15:0] rdata  [2];
    logic        ack    [2];
    logic        busy   [2];

    int tests = 0;
    int fails = 0;

    // Reference store keyed by sel*8192 + line address; absent key = never written.
    logic [63:0] mdl [int];

    ram_line_responder #(.ADDR_SIZE(13), .WORD_SIZE(16), .LINE_WIDTH(64), .LATENCY(3)) dut (
        .ram_clk(clk), .ram_rst(rst[0]), .ram_addr(addr[0]), .ram_avalid(avalid[0]),
        .ram_rnw(rnw[0]), .ram_wdata(wdata[0]), .ram_rdata(rdata[0]), .ram_ack(ack[0]),
        .ram_busy(busy[0])
    );

    ram_line_responder #(.ADDR_SIZE(13), .WORD_SIZE(16), .LINE_WIDTH(64), .LATENCY(1)) dut1 (
        .ram_clk(clk), .ram_rst(rst[1]), .ram_addr(addr[1]), .ram_avalid(avalid[1]),
        .ram_rnw(rnw[1]), .ram_wdata(wdata[1]), .ram_rdata(rdata[1]), .ram_ack(ack[1]),
        .ram_busy(busy[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_beat(input int sel, input logic [12:0] a, input int k);
        int          key;
        logic [63:0] line;
        key = sel * 8192 + int'(a);
        if (mdl.exists(key)) begin
            line = mdl[key];
            return line[16*k +: 16];
        end
`ifdef RAM_RESP_PATTERN_EN
        return {4'(k + 1), a[11:0]};
`else
        return 16'h0000;
`endif
    endfunction

    // Read accepted at edge T: ack during T+lat..T+lat+3, busy from T until after last ack.
    // inj_j >= 0 pulses a stray read request sampled at edge T+inj_j+1.
    task automatic do_read(input int sel, input int lat, input logic [12:0] a,
                           input int inj_j, input logic [12:0] inj_a);
        logic [15:0] e [4];
        for (int k = 0; k < 4; k++) e[k] = exp_beat(sel, a, k);
        addr[sel] = a; rnw[sel] = 1'b1; avalid[sel] = 1'b1;
        tick;
        avalid[sel] = 1'b0;
        for (int j = 0; j <= lat + 5; j++) begin
            logic        on;
            logic [15:0] ed;
            on = (j >= lat) && (j <= lat + 3);
            ed = 16'h0;
            if (on) ed = e[j - lat];
            check_eq("rd_ack", 32'(ack[sel]), 32'(on));
            check_eq("rd_data", 32'(rdata[sel]), 32'(ed));
            check_eq("rd_busy", 32'(busy[sel]), 32'(j <= lat + 3));
            if (j == inj_j) begin
                avalid[sel] = 1'b1; rnw[sel] = 1'b1; addr[sel] = inj_a;
            end else begin
                avalid[sel] = 1'b0;
            end
            tick;
        end
    endtask

    // Write accepted at edge T with beats at T..T+3: single ack at T+3+lat.
    task automatic do_write(input int sel, input int lat, input logic [12:0] a, input logic [63:0] line);
        addr[sel] = a; rnw[sel] = 1'b0; avalid[sel] = 1'b1; wdata[sel] = line[15:0];
        tick;
        avalid[sel] = 1'b0;
        mdl[sel * 8192 + int'(a)] = line;
        for (int j = 0; j <= lat + 5; j++) begin
            check_eq("wr_ack", 32'(ack[sel]), 32'(j == lat + 3));
            check_eq("wr_data", 32'(rdata[sel]), 32'h0);
            check_eq("wr_busy", 32'(busy[sel]), 32'(j <= lat + 3));
            if (j < 3) wdata[sel] = line[16*(j+1) +: 16];
            tick;
        end
    endtask

    task automatic model_reset(input int sel);
`ifdef RAM_RESP_PATTERN_EN
        int kill [$];
        foreach (mdl[k]) if (k / 8192 == sel) kill.push_back(k);
        foreach (kill[i]) mdl.delete(kill[i]);
`endif
    endtask

    // Reset lands on the edge that would sample beat 2; nothing may be committed.
    task automatic do_write_reset(input logic [12:0] a, input logic [63:0] line);
        addr[0] = a; rnw[0] = 1'b0; avalid[0] = 1'b1; wdata[0] = line[15:0];
        tick;
        avalid[0] = 1'b0; wdata[0] = line[31:16];
        tick;
        wdata[0] = line[47:32]; rst[0] = 1'b1;
        tick;
        rst[0] = 1'b0;
        model_reset(0);
        check_eq("rst_ack", 32'(ack[0]), 32'h0);
        check_eq("rst_busy", 32'(busy[0]), 32'h0);
        check_eq("rst_data", 32'(rdata[0]), 32'h0);
        tick;
        check_eq("rst_idle_busy", 32'(busy[0]), 32'h0);
    endtask

    function automatic logic [12:0] rand_addr();
        if ($urandom_range(0, 2) == 0) return 13'($urandom);
        return 13'h0C0 + 13'($urandom_range(0, 7));
    endfunction

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; avalid[s] = 1'b0; rnw[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
        end
        repeat (3) tick;
        rst[0] = 1'b0; rst[1] = 1'b0;
        for (int s = 0; s < 2; s++) begin
            check_eq("reset_ack", 32'(ack[s]), 32'h0);
            check_eq("reset_busy", 32'(busy[s]), 32'h0);
            check_eq("reset_data", 32'(rdata[s]), 32'h0);
        end

        do_read(0, 3, 13'h101, -1, '0);
        do_write(0, 3, 13'h0C1, 64'h3000_2000_BEEF_F00D);
        do_read(0, 3, 13'h0C1, -1, '0);
        do_read(0, 3, 13'h101, 0, 13'h1F0);
        do_read(0, 3, 13'h1F0, -1, '0);
        do_read(0, 3, 13'h0C1, 6, 13'h0C2);
        do_write_reset(13'h055, 64'hDDDD_CCCC_BBBB_AAAA);
        do_read(0, 3, 13'h055, -1, '0);
        do_read(0, 3, 13'h0C1, -1, '0);

        for (int i = 0; i < 40; i++) begin
            logic [12:0] a;
            a = rand_addr();
            if ($urandom_range(0, 1) == 1) do_write(0, 3, a, {$urandom, $urandom});
            else do_read(0, 3, a, -1, '0);
        end

        do_read(1, 1, 13'h0AA, -1, '0);
        do_write(1, 1, 13'h0AA, 64'h1234_5678_9ABC_DEF0);
        do_read(1, 1, 13'h0AA, -1, '0);
        for (int i = 0; i < 12; i++) begin
            logic [12:0] a;
            a = rand_addr();
            if ($urandom_range(0, 1) == 1) do_write(1, 1, a, {$urandom, $urandom});
            else do_read(1, 1, a, -1, '0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
